// File: rtl/core_wb_pkg.sv
// Shared types for the core-to-Wishbone bridge.
// Watchdog is built only with CORE_WB_TIMEOUT_EN.
package core_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    BUS_ERR,
    TIMEOUT
  } cause_t;

  localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/core_wb_if.sv
// Core request/response plus Wishbone classic signals.
// master = core and bus slave side, slave = bridge side.
interface core_wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [SEL_W-1:0]      be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [SEL_W-1:0]      wb_sel;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0] wb_wdat;
  logic [DATA_WIDTH-1:0] wb_rdat;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    output req, we, be, addr, wdata,
    output wb_rdat, wb_ack, wb_err,
    input  gnt, rvalid, rdata, err,
    input  wb_cyc, wb_stb, wb_we,
    input  wb_sel, wb_adr, wb_wdat
  );

  modport slave (
    input  req, we, be, addr, wdata,
    input  wb_rdat, wb_ack, wb_err,
    output gnt, rvalid, rdata, err,
    output wb_cyc, wb_stb, wb_we,
    output wb_sel, wb_adr, wb_wdat
  );

endinterface

// File: rtl/core_wb_bridge_fsm.sv
// IDLE/BUS/RESP sequencer between core port and Wishbone.
// Watchdog exit only with CORE_WB_TIMEOUT_EN.
module core_wb_bridge_fsm
  import core_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic       clk_i,
  input logic       rstn_i,
  core_wb_if.slave  bus
);

  state_t state;
  cause_t cause;
  logic   expired;
  logic   done;

`ifdef CORE_WB_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear   (state == IDLE),
    .enable  (state == BUS),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // rstn_i term keeps gnt low while reset is held
  assign bus.gnt = rstn_i && (state == IDLE) && bus.req;

  assign done = bus.wb_ack || bus.wb_err || expired;

  always_comb begin
    cause = NONE;
    if (!bus.wb_ack) begin
      if (bus.wb_err) cause = BUS_ERR;
      else if (expired) cause = TIMEOUT;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.err     <= 1'b0;
      bus.wb_cyc  <= 1'b0;
      bus.wb_stb  <= 1'b0;
      bus.wb_we   <= 1'b0;
      bus.wb_sel  <= '0;
      bus.wb_adr  <= '0;
      bus.wb_wdat <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            bus.wb_we   <= bus.we;
            bus.wb_sel  <= bus.be;
            bus.wb_adr  <= bus.addr;
            bus.wb_wdat <= bus.wdata;
            bus.wb_cyc  <= 1'b1;
            bus.wb_stb  <= 1'b1;
            state       <= BUS;
          end
        end
        BUS: begin
          if (done) begin
            bus.wb_cyc <= 1'b0;
            bus.wb_stb <= 1'b0;
            bus.rvalid <= 1'b1;
            bus.err    <= (cause != NONE);
            bus.rdata  <= (cause == NONE && !bus.wb_we)
                          ? bus.wb_rdat : '0;
            state      <= RESP;
          end
        end
        RESP: begin
          bus.rvalid <= 1'b0;
          bus.err    <= 1'b0;
          bus.rdata  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_timeout_counter.sv
// Bus watchdog: counts BUS cycles, flags the last allowed one.
// Instantiated only with CORE_WB_TIMEOUT_EN.
module wb_timeout_counter
  import core_wb_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // expired marks the LIMIT-th BUS cycle so the exit edge ends it
  assign expired = enable &&
                   (count == TMR_W'(LIMIT - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/core_wb_bridge.sv
// Core-to-Wishbone classic bridge, one transaction in flight.
// Define CORE_WB_TIMEOUT_EN to build the bus watchdog.
module core_wb_bridge #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  core_wb_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) bus ();

  assign bus.req     = req_i;
  assign bus.we      = we_i;
  assign bus.be      = be_i;
  assign bus.addr    = addr_i;
  assign bus.wdata   = wdata_i;
  assign bus.wb_rdat = wb_dat_i;
  assign bus.wb_ack  = wb_ack_i;
  assign bus.wb_err  = wb_err_i;

  assign gnt_o    = bus.gnt;
  assign rvalid_o = bus.rvalid;
  assign rdata_o  = bus.rdata;
  assign err_o    = bus.err;
  assign wb_cyc_o = bus.wb_cyc;
  assign wb_stb_o = bus.wb_stb;
  assign wb_we_o  = bus.wb_we;
  assign wb_sel_o = bus.wb_sel;
  assign wb_adr_o = bus.wb_adr;
  assign wb_dat_o = bus.wb_wdat;

  core_wb_bridge_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

endmodule

// File: tb/tb_core_wb_bridge.sv
// Self-checking bench for core_wb_bridge.
// Timeout scenario runs when CORE_WB_TIMEOUT_EN is defined.
module tb_core_wb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  core_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  core_wb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .req_i    (bus.req),
    .we_i     (bus.we),
    .be_i     (bus.be),
    .addr_i   (bus.addr),
    .wdata_i  (bus.wdata),
    .gnt_o    (bus.gnt),
    .rvalid_o (bus.rvalid),
    .rdata_o  (bus.rdata),
    .err_o    (bus.err),
    .wb_cyc_o (bus.wb_cyc),
    .wb_stb_o (bus.wb_stb),
    .wb_we_o  (bus.wb_we),
    .wb_sel_o (bus.wb_sel),
    .wb_adr_o (bus.wb_adr),
    .wb_dat_o (bus.wb_wdat),
    .wb_dat_i (bus.wb_rdat),
    .wb_ack_i (bus.wb_ack),
    .wb_err_i (bus.wb_err)
  );

  task automatic idle_inputs();
    bus.req     = 1'b0;
    bus.we      = 1'b0;
    bus.be      = '0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.wb_rdat = '0;
    bus.wb_ack  = 1'b0;
    bus.wb_err  = 1'b0;
  endtask

  // resp: 0 = ack, 1 = err, 2 = ack and err together
  task automatic do_txn(
    input logic          we,
    input logic [SW-1:0] be,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] wdata,
    input int            delay,
    input int            resp,
    input logic [DW-1:0] rd,
    input string         tag
  );
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic [70:0]   exp_bus;
    logic [70:0]   got_bus;
    exp_err   = (resp == 1);
    exp_rdata = (resp != 1 && !we) ? rd : '0;
    exp_bus   = {1'b1, 1'b1, we, be, addr, wdata};
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.be    = be;
    bus.addr  = addr;
    bus.wdata = wdata;
    #1;
    checks++;
    if (bus.gnt !== 1'b1) begin
      errors++;
      $display("FAIL %s gnt: got %b want 1", tag, bus.gnt);
    end
    @(negedge clk);
    bus.req   = 1'b0;
    bus.we    = ~we;
    bus.be    = ~be;
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    for (int i = 0; i <= delay; i++) begin
      got_bus = {bus.wb_cyc, bus.wb_stb, bus.wb_we,
                 bus.wb_sel, bus.wb_adr, bus.wb_wdat};
      checks++;
      if (got_bus !== exp_bus) begin
        errors++;
        $display("FAIL %s bus_hold[%0d]: got %h want %h",
                 tag, i, got_bus, exp_bus);
      end
      if (i == delay) begin
        bus.wb_ack  = (resp != 1);
        bus.wb_err  = (resp != 0);
        bus.wb_rdat = rd;
      end
      @(negedge clk);
    end
    bus.wb_ack  = 1'b0;
    bus.wb_err  = 1'b0;
    bus.wb_rdat = $urandom;
    checks++;
    if ({bus.rvalid, bus.err, bus.rdata,
         bus.wb_cyc, bus.wb_stb} !==
        {1'b1, exp_err, exp_rdata, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s resp: got rv=%b err=%b rd=%h cyc=%b want rv=1 err=%b rd=%h cyc=0",
               tag, bus.rvalid, bus.err, bus.rdata,
               bus.wb_cyc, exp_err, exp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({bus.rvalid, bus.wb_cyc} !== 2'b00) begin
      errors++;
      $display("FAIL %s after: got rv=%b cyc=%b want 0 0",
               tag, bus.rvalid, bus.wb_cyc);
    end
  endtask

  task automatic test_reset();
    logic [139:0] outs;
    idle_inputs();
    rstn       = 1'b0;
    bus.req    = 1'b1;
    bus.wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      outs = {bus.gnt, bus.rvalid, bus.rdata, bus.err,
              bus.wb_cyc, bus.wb_stb, bus.wb_we,
              bus.wb_sel, bus.wb_adr, bus.wb_wdat};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outs: got %h want 0", outs);
      end
    end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_read();
    do_txn(1'b0, 4'hF, 32'h100, 32'h0, 0, 0,
           32'hDEADBEEF, "read");
  endtask

  task automatic test_write();
    do_txn(1'b1, 4'b0011, 32'h200, 32'h12345678, 2, 0,
           32'hA5A5A5A5, "write");
  endtask

  task automatic test_bus_error();
    do_txn(1'b0, 4'hF, 32'h300, 32'h0, 2, 1,
           32'h11112222, "bus_err");
    do_txn(1'b0, 4'hF, 32'h304, 32'h0, 2, 2,
           32'hCAFEF00D, "ack_over_err");
    do_txn(1'b1, 4'hF, 32'h308, 32'h55AA55AA, 1, 1,
           32'h0, "wr_err");
  endtask

  task automatic test_zero_be();
    do_txn(1'b1, 4'b0000, 32'h400, 32'h87654321, 1, 0,
           32'h0, "be_zero");
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    bus.wb_ack  = 1'b1;
    bus.wb_err  = 1'b1;
    bus.wb_rdat = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rvalid, bus.err, bus.wb_cyc} !== 3'b000) begin
        errors++;
        $display("FAIL stray_ack: got rv=%b err=%b cyc=%b want 0",
                 bus.rvalid, bus.err, bus.wb_cyc);
      end
    end
    idle_inputs();
  endtask

`ifdef CORE_WB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = 32'h500;
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (bus.wb_cyc === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want %0d", n, TO);
    end
    checks++;
    if ({bus.rvalid, bus.err, bus.rdata} !==
        {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL timeout_resp: got rv=%b err=%b rd=%h want 1 1 0",
               bus.rvalid, bus.err, bus.rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got rv=%b want 0", bus.rvalid);
    end
  endtask
`else
  task automatic test_no_timeout();
    int n_cyc;
    int n_rv;
    n_cyc = 0;
    n_rv  = 0;
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = 32'h500;
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.wb_cyc === 1'b1) n_cyc++;
      if (bus.rvalid === 1'b1) n_rv++;
      @(negedge clk);
    end
    checks++;
    if (n_cyc !== 20 || n_rv !== 0) begin
      errors++;
      $display("FAIL no_timeout_wait: got cyc=%0d rv=%0d want 20 0",
               n_cyc, n_rv);
    end
    bus.wb_ack  = 1'b1;
    bus.wb_rdat = 32'h0BADCAFE;
    @(negedge clk);
    bus.wb_ack = 1'b0;
    checks++;
    if ({bus.rvalid, bus.err, bus.rdata} !==
        {1'b1, 1'b0, 32'h0BADCAFE}) begin
      errors++;
      $display("FAIL no_timeout_resp: got rv=%b err=%b rd=%h",
               bus.rvalid, bus.err, bus.rdata);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_bus();
    int n_rv;
    n_rv = 0;
    @(negedge clk);
    bus.req  = 1'b1;
    bus.addr = 32'h600;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got cyc=%b want 1", bus.wb_cyc);
    end
    #2;
    rstn    = 1'b0;
    bus.req = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc, bus.wb_stb, bus.rvalid, bus.gnt} !== 4'b0) begin
      errors++;
      $display("FAIL rst_abort: got cyc=%b stb=%b rv=%b gnt=%b want 0",
               bus.wb_cyc, bus.wb_stb, bus.rvalid, bus.gnt);
    end
    bus.wb_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rvalid === 1'b1 || bus.wb_cyc === 1'b1) n_rv++;
    end
    checks++;
    if (n_rv !== 0) begin
      errors++;
      $display("FAIL rst_no_resp: got %0d active cycles want 0", n_rv);
    end
    do_txn(1'b0, 4'hF, 32'h604, 32'h0, 1, 0,
           32'h600DF00D, "rst_fresh");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_gnt;
    logic [5:0] exp_cyc;
    logic [5:0] exp_rv;
    int         n_gnt;
    int         n_rv;
    exp_gnt = 6'b001001;
    exp_cyc = 6'b010010;
    exp_rv  = 6'b100100;
    n_gnt   = 0;
    n_rv    = 0;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.be    = 4'hF;
    bus.addr  = 32'h700;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({bus.gnt, bus.wb_cyc, bus.rvalid} !==
          {exp_gnt[c], exp_cyc[c], exp_rv[c]}) begin
        errors++;
        $display("FAIL b2b[%0d]: got gnt=%b cyc=%b rv=%b want %b %b %b",
                 c, bus.gnt, bus.wb_cyc, bus.rvalid,
                 exp_gnt[c], exp_cyc[c], exp_rv[c]);
      end
      if (bus.gnt === 1'b1) n_gnt++;
      if (bus.rvalid === 1'b1) n_rv++;
      bus.wb_ack  = bus.wb_cyc;
      bus.wb_rdat = $urandom;
      if (c == 5) bus.req = 1'b0;
      @(negedge clk);
    end
    bus.wb_ack = 1'b0;
    checks++;
    if (n_gnt !== 2 || n_rv !== 2 || bus.wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got gnt=%0d rv=%0d cyc=%b want 2 2 0",
               n_gnt, n_rv, bus.wb_cyc);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 7);
      do_txn(1'($urandom_range(0, 1)), SW'($urandom),
             AW'($urandom) & ~AW'(3), DW'($urandom),
             $urandom_range(0, 3),
             (r < 6) ? 0 : r - 5,
             DW'($urandom), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bus_error();
    test_zero_be();
    test_stray_ack();
`ifdef CORE_WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
